// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared constants, quadrant encoding and arctangent table for
//               the rotation-mode CORDIC polar-to-rectangular converter.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int c_angle_w      = 16;
    localparam int c_mag_w        = 16;
    localparam int c_atan_entries = 16;
    // 1/K in Q0.16, applied only when gain compensation is built in
    localparam int c_inv_gain     = 39797;

    // Quadrant is the top two bits of the binary angle
    typedef enum logic [1:0] {
        QUAD_0   = 2'd0,
        QUAD_90  = 2'd1,
        QUAD_180 = 2'd2,
        QUAD_270 = 2'd3
    } quad_e;

    // atan(2^-i) in binary-angle units (full circle = 65536), rounded
    function automatic int atan_lut(input int idx);
        if (idx < 0 || idx >= c_atan_entries) begin
            return 0;
        end
        case (idx)
            0:       return 8192;
            1:       return 4836;
            2:       return 2555;
            3:       return 1297;
            4:       return 651;
            5:       return 326;
            6:       return 163;
            7:       return 81;
            8:       return 41;
            9:       return 20;
            10:      return 10;
            11:      return 5;
            12:      return 3;
            13:      return 1;
            14:      return 1;
            default: return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_rotator_if.sv
`default_nettype none
// ============================================================================
// Module      : cordic_rotator_if
// Description : Sample-stream bundle for the CORDIC rotator: polar input
//               (Rin, Ain) and rectangular output (Xout, Yout) with valids.
// Revision    : 1.0 - initial release
// ============================================================================
interface cordic_rotator_if
    import cordic_pkg::*;
#(
    parameter int IW = 20
);
    logic                    valid_in;
    logic [c_mag_w-1:0]      Rin;
    logic [c_angle_w-1:0]    Ain;
    logic                    valid_out;
    logic signed [IW-1:0]    Xout;
    logic signed [IW-1:0]    Yout;

    modport master (
        output valid_in, Rin, Ain,
        input  valid_out, Xout, Yout
    );

    modport slave (
        input  valid_in, Rin, Ain,
        output valid_out, Xout, Yout
    );
endinterface
`default_nettype wire

// File: rtl/cordic_rot_stage.sv
`default_nettype none
// ============================================================================
// Module      : cordic_rot_stage
// Description : One registered CORDIC micro-rotation (rotation mode): the
//               sign of the residual angle picks the rotation direction.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_rot_stage #(
    parameter int IW       = 20,
    parameter int ZW       = 17,
    parameter int SHIFT    = 0,
    parameter int ATAN_VAL = 0
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 i_ena,
    input  wire logic                 i_valid,
    input  wire logic signed [IW-1:0] i_x,
    input  wire logic signed [IW-1:0] i_y,
    input  wire logic signed [ZW-1:0] i_z,
    output logic                      o_valid,
    output logic signed [IW-1:0]      o_x,
    output logic signed [IW-1:0]      o_y,
    output logic signed [ZW-1:0]      o_z
);

    localparam logic signed [ZW-1:0] c_atan = ZW'(ATAN_VAL);

    logic signed [IW-1:0] w_x_sh;
    logic signed [IW-1:0] w_y_sh;
    logic                 w_rot_pos;

    // Truncating arithmetic shifts; no rounding anywhere in the chain
    assign w_x_sh    = i_x >>> SHIFT;
    assign w_y_sh    = i_y >>> SHIFT;
    assign w_rot_pos = ~i_z[ZW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_z     <= '0;
        end else if (i_ena) begin
            o_valid <= i_valid;
            if (w_rot_pos) begin
                o_x <= i_x - w_y_sh;
                o_y <= i_y + w_x_sh;
                o_z <= i_z - c_atan;
            end else begin
                o_x <= i_x + w_y_sh;
                o_y <= i_y - w_x_sh;
                o_z <= i_z + c_atan;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_rotator.sv
`default_nettype none
// ============================================================================
// Module      : cordic_rotator
// Description : Fully pipelined rotation-mode CORDIC, (R, A) -> (R.cos, R.sin).
//               Define CORDIC_GAIN_COMP_EN to add a 1/K scaling stage.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_rotator
    import cordic_pkg::*;
#(
    parameter int ITER = 16,
    parameter int IW   = 20
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       ena,
    cordic_rotator_if.slave bus
);

    // Residual angle: 14-bit in-quadrant angle plus headroom for the sign
    localparam int ZW = c_angle_w + 1;

    // ------------------------------------------------------------------
    // Stage 0: quadrant pre-rotation
    // ------------------------------------------------------------------
    quad_e                w_quad;
    logic signed [IW-1:0] w_r_ext;
    logic signed [IW-1:0] w_x_pre;
    logic signed [IW-1:0] w_y_pre;
    logic signed [ZW-1:0] w_z_pre;

    logic                 r_v0;
    logic signed [IW-1:0] r_x0;
    logic signed [IW-1:0] r_y0;
    logic signed [ZW-1:0] r_z0;

    assign w_quad  = quad_e'(bus.Ain[c_angle_w-1 -: 2]);
    assign w_r_ext = {{(IW - c_mag_w){1'b0}}, bus.Rin};
    assign w_z_pre = {3'b000, bus.Ain[c_angle_w-3:0]};

    always_comb begin
        w_x_pre = '0;
        w_y_pre = '0;
        case (w_quad)
            QUAD_0:   w_x_pre =  w_r_ext;
            QUAD_90:  w_y_pre =  w_r_ext;
            QUAD_180: w_x_pre = -w_r_ext;
            QUAD_270: w_y_pre = -w_r_ext;
            default: begin
                w_x_pre = '0;
                w_y_pre = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= 1'b0;
            r_x0 <= '0;
            r_y0 <= '0;
            r_z0 <= '0;
        end else if (ena) begin
            r_v0 <= bus.valid_in;
            r_x0 <= w_x_pre;
            r_y0 <= w_y_pre;
            r_z0 <= w_z_pre;
        end
    end

    // ------------------------------------------------------------------
    // Micro-rotation chain
    // ------------------------------------------------------------------
    logic                 w_v [ITER+1];
    logic signed [IW-1:0] w_x [ITER+1];
    logic signed [IW-1:0] w_y [ITER+1];
    logic signed [ZW-1:0] w_z [ITER+1];

    assign w_v[0] = r_v0;
    assign w_x[0] = r_x0;
    assign w_y[0] = r_y0;
    assign w_z[0] = r_z0;

    for (genvar gi = 0; gi < ITER; gi++) begin : g_stage
        cordic_rot_stage #(
            .IW       (IW),
            .ZW       (ZW),
            .SHIFT    (gi),
            .ATAN_VAL (atan_lut(gi))
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_ena   (ena),
            .i_valid (w_v[gi]),
            .i_x     (w_x[gi]),
            .i_y     (w_y[gi]),
            .i_z     (w_z[gi]),
            .o_valid (w_v[gi+1]),
            .o_x     (w_x[gi+1]),
            .o_y     (w_y[gi+1]),
            .o_z     (w_z[gi+1])
        );
    end

    // The final residual angle is only a convergence by-product
    logic w_unused_z;
    assign w_unused_z = ^w_z[ITER];

    // ------------------------------------------------------------------
    // Optional gain compensation
    // ------------------------------------------------------------------
    logic                 w_v_fin;
    logic signed [IW-1:0] w_x_fin;
    logic signed [IW-1:0] w_y_fin;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = IW + 18;
    localparam logic signed [PW-1:0] c_gain  = PW'(c_inv_gain);
    localparam logic signed [PW-1:0] c_round = PW'(32768);

    logic signed [PW-1:0] w_px;
    logic signed [PW-1:0] w_py;
    logic                 r_vc;
    logic signed [IW-1:0] r_xc;
    logic signed [IW-1:0] r_yc;

    // Q0.16 product, round half up, then drop the fraction
    assign w_px = PW'(w_x[ITER]) * c_gain + c_round;
    assign w_py = PW'(w_y[ITER]) * c_gain + c_round;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vc <= 1'b0;
            r_xc <= '0;
            r_yc <= '0;
        end else if (ena) begin
            r_vc <= w_v[ITER];
            r_xc <= w_px[IW+15:16];
            r_yc <= w_py[IW+15:16];
        end
    end

    logic w_unused_prod;
    assign w_unused_prod = ^{w_px[PW-1:IW+16], w_px[15:0], w_py[PW-1:IW+16], w_py[15:0]};

    assign w_v_fin = r_vc;
    assign w_x_fin = r_xc;
    assign w_y_fin = r_yc;
`else
    assign w_v_fin = w_v[ITER];
    assign w_x_fin = w_x[ITER];
    assign w_y_fin = w_y[ITER];
`endif

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic                 r_vout;
    logic signed [IW-1:0] r_xout;
    logic signed [IW-1:0] r_yout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vout <= 1'b0;
            r_xout <= '0;
            r_yout <= '0;
        end else if (ena) begin
            r_vout <= w_v_fin;
            r_xout <= w_x_fin;
            r_yout <= w_y_fin;
        end
    end

    assign bus.valid_out = r_vout;
    assign bus.Xout      = r_xout;
    assign bus.Yout      = r_yout;

endmodule
`default_nettype wire

// File: tb/tb_cordic_rotator.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_rotator
// Description : Scoreboard bench for cordic_rotator: integer CORDIC reference
//               plus ideal-trig sanity on directed points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_rotator;

    localparam int ITER = 16;
    localparam int IW   = 20;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LAT    = ITER + 3;
    localparam real GSCALE = 39797.0 / 65536.0;
`else
    localparam int  LAT    = ITER + 2;
    localparam real GSCALE = 1.0;
`endif
    localparam int  IDEAL_TOL = 24;
    localparam real TWO_PI    = 6.283185307179586;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    bit   want_ideal = 1'b0;

    cordic_rotator_if #(.IW(IW)) bus ();

    cordic_rotator #(
        .ITER (ITER),
        .IW   (IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit ideal;
        int ix;
        int iy;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    real  kg     = 1.0;
    int   atan_tab [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                            41, 20, 10, 5, 3, 1, 1, 0};

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_near(input string tag, input int obs, input int expv, input int tol);
        checks++;
        assert ((obs - expv <= tol) && (expv - obs <= tol)) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
        end
    endtask

    // Integer reference of the rotation-mode algorithm
    function automatic void cordic_model(input int r, input int a, output int xo, output int yo);
        longint x, y, z, t;
        int q;
        q = (a >> 14) & 3;
        x = 0;
        y = 0;
        case (q)
            0: x =  longint'(r);
            1: y =  longint'(r);
            2: x = -longint'(r);
            default: y = -longint'(r);
        endcase
        z = longint'(a & 16'h3FFF);
        for (int i = 0; i < ITER; i++) begin
            t = x;
            if (z >= 0) begin
                x = x - (y >>> i);
                y = y + (t >>> i);
                z = z - atan_tab[i];
            end else begin
                x = x + (y >>> i);
                y = y - (t >>> i);
                z = z + atan_tab[i];
            end
        end
`ifdef CORDIC_GAIN_COMP_EN
        x = (x * 39797 + 32768) >>> 16;
        y = (y * 39797 + 32768) >>> 16;
`endif
        xo = int'(x);
        yo = int'(y);
    endfunction

    // ------------------------------------------------------------------
    // Monitor: push at enabled sampling edges, pop LAT enabled edges later
    // ------------------------------------------------------------------
    logic [LAT-1:0] vexp = '0;
    bit hold_known = 1'b0;
    int hold_x = 0;
    int hold_y = 0;

    always @(posedge clk) begin
        bit   s_ena;
        bit   s_rst;
        exp_t e;
        int   mx, my;
        real  th;
        s_ena = ena;
        s_rst = !rst_n;
        if (s_rst) begin
            vexp = '0;
            sb.delete();
            hold_known = 1'b0;
        end else if (s_ena) begin
            vexp = {vexp[LAT-2:0], bus.valid_in};
            if (bus.valid_in) begin
                cordic_model(int'(bus.Rin), int'(bus.Ain), mx, my);
                e.x     = mx;
                e.y     = my;
                e.ideal = want_ideal;
                th      = real'(bus.Ain) * TWO_PI / 65536.0;
                e.ix    = int'(real'(bus.Rin) * kg * GSCALE * $cos(th));
                e.iy    = int'(real'(bus.Rin) * kg * GSCALE * $sin(th));
                sb.push_back(e);
            end
        end
        #1;
        check_eq("valid_out", 32'(bus.valid_out), 32'(vexp[LAT-1]));
        if (s_rst) begin
            check_eq("rst_xout", 32'(bus.Xout), 0);
            check_eq("rst_yout", 32'(bus.Yout), 0);
        end else if (s_ena) begin
            if (vexp[LAT-1]) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL sb_underflow: observed=%0d expected=%0d", sb.size(), 1);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("xout", 32'(bus.Xout), e.x);
                    check_eq("yout", 32'(bus.Yout), e.y);
                    if (e.ideal) begin
                        check_near("xout_ideal", int'(bus.Xout), e.ix, IDEAL_TOL);
                        check_near("yout_ideal", int'(bus.Yout), e.iy, IDEAL_TOL);
                    end
                    hold_known = 1'b1;
                    hold_x     = e.x;
                    hold_y     = e.y;
                end
            end else begin
                hold_known = 1'b0;
            end
        end else if (hold_known) begin
            check_eq("hold_xout", 32'(bus.Xout), hold_x);
            check_eq("hold_yout", 32'(bus.Yout), hold_y);
        end
    end

    task automatic drive(input bit v, input int r, input int a, input bit id);
        @(negedge clk);
        ena          = 1'b1;
        bus.valid_in = v;
        bus.Rin      = 16'(r);
        bus.Ain      = 16'(a);
        want_ideal   = id;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 0, 0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < ITER; i++) begin
            kg = kg * $sqrt(1.0 + 1.0 / $pow(4.0, real'(i)));
        end
        bus.valid_in = 1'b0;
        bus.Rin      = '0;
        bus.Ain      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("reset_valid_out", 32'(bus.valid_out), 0);
        check_eq("reset_xout",      32'(bus.Xout), 0);
        check_eq("reset_yout",      32'(bus.Yout), 0);
        rst_n = 1'b1;

        // Axes, diagonal, full scale, zero magnitude, wrap point
        drive(1'b1, 10000, 16'h0000, 1'b1);
        drive(1'b1, 10000, 16'h4000, 1'b1);
        drive(1'b1, 10000, 16'h8000, 1'b1);
        drive(1'b1, 10000, 16'hC000, 1'b1);
        drive(1'b1, 10000, 16'h2000, 1'b1);
        drive(1'b1, 65535, 16'h2000, 1'b0);
        drive(1'b1, 0,     16'h5A5A, 1'b1);
        drive(1'b1, 30000, 16'hFFFF, 1'b0);
        drive(1'b0, 0,     0,        1'b0);
        drive(1'b1, 10000, 16'hE000, 1'b1);
        drive(1'b1, 65535, 16'h0000, 1'b0);
        drive(1'b1, 65535, 16'hBFFF, 1'b0);
        idle(LAT + 2);

        // Random stream with toggling valid
        for (int i = 0; i < 64; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 65535)), 1'b0);
        end
        idle(LAT + 2);

        // Clock-enable freeze in the middle of a continuous stream
        for (int i = 0; i < LAT + 4; i++) begin
            drive(1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ena          = 1'b0;
            bus.valid_in = 1'b1;
            bus.Rin      = 16'($urandom_range(0, 65535));
            bus.Ain      = 16'($urandom_range(0, 65535));
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'b0);
        end
        idle(LAT + 2);

        // Asynchronous reset between edges while outputs are active
        for (int i = 0; i < LAT + 6; i++) begin
            drive(1'b1, int'($urandom_range(1000, 65535)), int'($urandom_range(0, 65535)), 1'b0);
        end
        #2;
        check_eq("pre_reset_valid_out", 32'(bus.valid_out), 1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid_out", 32'(bus.valid_out), 0);
        check_eq("async_rst_xout",      32'(bus.Xout), 0);
        check_eq("async_rst_yout",      32'(bus.Yout), 0);
        @(negedge clk);
        @(negedge clk);
        bus.valid_in = 1'b0;
        rst_n        = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'b0);
        end
        idle(LAT + 4);

        check_eq("scoreboard_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
